// File: rtl/qtr8_sim.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qtr8_sim : eight-channel Pololu QTR-RC sensor emulator (sensor side of the   |
// |            charge/discharge handshake) with bus-programmable discharge times.|
// | Optional build macro: QTR8SIM_AUTOSEND_EN (poll reports completed cycles).   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+

`ifndef MXCLK
`define MXCLK 7
`endif
`ifndef U10CLK
`define U10CLK 3
`endif

module qtr8_sim #(
  parameter int NCH = 8
) (
  input  logic            CLK_I,
  input  logic            RST_N,
  input  logic            WE_I,
  input  logic            TGA_I,
  input  logic            STB_I,
  input  logic [7:0]      ADR_I,
  output logic            STALL_O,
  output logic            ACK_O,
  input  logic [7:0]      DAT_I,
  output logic [7:0]      DAT_O,
  input  logic [`MXCLK:0] clocks,
  inout  wire  [NCH-1:0]  pins
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DETECT  = 2'd1,
    S_COUNT   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [8:0] c_tick_max = 9'h1FF;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_armed;
  logic           w_armed_nxt;
  logic           r_guard;
  logic           w_guard_nxt;
  logic [8:0]     r_tick;
  logic [8:0]     w_tick_nxt;
  logic           w_cyc_done;

  logic [NCH-1:0] r_sync1;
  logic [NCH-1:0] r_psync;
  logic [7:0]     r_dtime [NCH];
  logic [NCH-1:0] r_enmask;
  logic [7:0]     r_cyccount;
  logic           w_data_avail;

  logic           w_u10;
  logic           w_myaddr;
  logic           w_wr;
  logic           w_rd;
  logic [NCH-1:0] w_act;
  logic [NCH-1:0] w_hi;
  logic [NCH-1:0] w_pin_oe;
  logic [NCH-1:0] w_pin_do;
  logic [7:0]     w_reg_rd;
  logic           w_unused;

  assign w_u10    = clocks[`U10CLK];
  assign w_unused = ^clocks;
  assign w_myaddr = STB_I && (ADR_I[7:4] == 4'h0);
  assign w_wr     = w_myaddr && TGA_I && WE_I;
  assign w_rd     = w_myaddr && TGA_I && !WE_I;
  assign w_act    = r_psync & r_enmask;
  assign STALL_O  = 1'b0;
  assign ACK_O    = w_myaddr;

  // A channel stays high while the shared tick is below its own discharge time.
  generate
    for (genvar n = 0; n < NCH; n++) begin : g_ch
      assign w_hi[n]  = r_enmask[n] && (r_tick < {1'b0, r_dtime[n]});
      assign pins[n]  = w_pin_oe[n] ? w_pin_do[n] : 1'bz;
    end
  endgenerate

  always_ff @(posedge CLK_I or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_armed <= 1'b0;
      r_guard <= 1'b0;
      r_tick  <= 9'd0;
    end else begin
      r_state <= w_state_nxt;
      r_armed <= w_armed_nxt;
      r_guard <= w_guard_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_armed_nxt = r_armed;
    w_guard_nxt = r_guard;
    w_tick_nxt  = r_tick;
    w_cyc_done  = 1'b0;
    w_pin_oe    = '0;
    w_pin_do    = '0;
    case (r_state)
      S_IDLE: begin
        if (r_armed && (w_act != '0)) begin
          w_state_nxt = S_DETECT;
          w_armed_nxt = 1'b0;
          w_guard_nxt = 1'b0;
        end else if (w_act == '0) begin
          w_armed_nxt = 1'b1;
        end
      end
      S_DETECT: begin
        w_pin_oe = r_enmask;
        w_pin_do = {NCH{1'b1}};
        // Two u10 pulses guarantee the reader's full 10us charge has elapsed.
        if (r_enmask == '0) begin
          w_state_nxt = S_RELEASE;
        end else if (w_u10) begin
          if (r_guard) begin
            w_state_nxt = S_COUNT;
            w_tick_nxt  = 9'd0;
            w_guard_nxt = 1'b0;
          end else begin
            w_guard_nxt = 1'b1;
          end
        end
      end
      S_COUNT: begin
        w_pin_oe = r_enmask;
        w_pin_do = w_hi;
        if (w_u10 && (r_tick != c_tick_max))
          w_tick_nxt = r_tick + 9'd1;
        if (w_hi == '0)
          w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        w_pin_oe = r_enmask;
        w_pin_do = '0;
        if (w_u10) begin
          w_state_nxt = S_IDLE;
          w_cyc_done  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1    <= '0;
      r_psync    <= '0;
      r_enmask   <= '0;
      r_cyccount <= 8'h00;
      for (int i = 0; i < NCH; i++)
        r_dtime[i] <= 8'h00;
    end else begin
      r_sync1 <= pins;
      r_psync <= r_sync1;
      if (w_cyc_done)
        r_cyccount <= r_cyccount + 8'd1;
      if (w_wr) begin
        if (!ADR_I[3])
          r_dtime[ADR_I[2:0]] <= DAT_I;
        else if (ADR_I[3:0] == 4'd8)
          r_enmask <= DAT_I;
      end
    end
  end

`ifdef QTR8SIM_AUTOSEND_EN
  logic r_data_avail;

  // Completion outranks a same-cycle host read so no finished cycle is lost.
  always_ff @(posedge CLK_I or negedge RST_N) begin
    if (!RST_N)
      r_data_avail <= 1'b0;
    else if (w_cyc_done)
      r_data_avail <= 1'b1;
    else if (w_rd)
      r_data_avail <= 1'b0;
  end

  assign w_data_avail = r_data_avail;
`else
  logic w_rd_unused;
  assign w_rd_unused  = w_rd;
  assign w_data_avail = 1'b0;
`endif

  always_comb begin
    w_reg_rd = 8'h00;
    if (!ADR_I[3])
      w_reg_rd = r_dtime[ADR_I[2:0]];
    else if (ADR_I[3:0] == 4'd8)
      w_reg_rd = r_enmask;
    else if (ADR_I[3:0] == 4'd9)
      w_reg_rd = r_cyccount;
  end

  always_comb begin
    DAT_O = 8'h00;
    if (!w_myaddr)
      DAT_O = DAT_I;
    else if (!TGA_I && w_data_avail)
      DAT_O = 8'h01;
    else if (TGA_I)
      DAT_O = w_reg_rd;
  end

endmodule

`default_nettype wire

// File: tb/tb_qtr8_sim.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_qtr8_sim : directed self-checking bench for qtr8_sim.                    |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+

`ifndef MXCLK
`define MXCLK 7
`endif
`ifndef U10CLK
`define U10CLK 3
`endif

module tb_qtr8_sim;

`ifdef QTR8SIM_AUTOSEND_EN
  localparam logic [15:0] c_poll_done = 16'h0001;
`else
  localparam logic [15:0] c_poll_done = 16'h0000;
`endif

  logic            CLK_I = 1'b0;
  logic            RST_N;
  logic            WE_I;
  logic            TGA_I;
  logic            STB_I;
  logic [7:0]      ADR_I;
  logic [7:0]      DAT_I;
  wire             STALL_O;
  wire             ACK_O;
  wire  [7:0]      DAT_O;
  logic [`MXCLK:0] clocks = '0;
  wire  [7:0]      pins;
  logic [7:0]      r_ext = 8'h00;

  int total = 0;
  int bad   = 0;
  int div   = 0;

  qtr8_sim dut (
    .CLK_I  (CLK_I),
    .RST_N  (RST_N),
    .WE_I   (WE_I),
    .TGA_I  (TGA_I),
    .STB_I  (STB_I),
    .ADR_I  (ADR_I),
    .STALL_O(STALL_O),
    .ACK_O  (ACK_O),
    .DAT_I  (DAT_I),
    .DAT_O  (DAT_O),
    .clocks (clocks),
    .pins   (pins)
  );

  // The external reader only ever drives high; otherwise the line floats.
  generate
    for (genvar i = 0; i < 8; i++) begin : g_ext
      assign pins[i] = r_ext[i] ? 1'b1 : 1'bz;
    end
  endgenerate

  always #5 CLK_I = ~CLK_I;

  // One-cycle u10 pulse every 10 clocks, changed on the falling edge.
  always @(negedge CLK_I) begin
    div = (div == 9) ? 0 : div + 1;
    clocks = '0;
    clocks[`U10CLK] = (div == 0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // {drive enables, driven values}; a released line shows enable 0, value 0.
  function automatic logic [15:0] pin_obs();
    return {dut.w_pin_oe, pins & dut.w_pin_oe};
  endfunction

  task automatic wait_pulse();
    int n;
    n = 0;
    do begin
      @(posedge CLK_I);
      n++;
    end while (!clocks[`U10CLK] && n < 50);
    if (!clocks[`U10CLK])
      check("u10 timeout", 16'd0, 16'd1);
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
    @(negedge CLK_I);
    STB_I = 1'b1; TGA_I = 1'b1; WE_I = 1'b1; ADR_I = addr; DAT_I = data;
    @(negedge CLK_I);
    STB_I = 1'b0; TGA_I = 1'b0; WE_I = 1'b0; DAT_I = 8'h00;
  endtask

  task automatic bus_read(input logic [7:0] addr, input logic tga, output logic [7:0] data);
    @(negedge CLK_I);
    STB_I = 1'b1; TGA_I = tga; WE_I = 1'b0; ADR_I = addr;
    #2 data = DAT_O;
    @(negedge CLK_I);
    STB_I = 1'b0; TGA_I = 1'b0;
  endtask

  task automatic run_cycle(input logic [7:0] mask);
    wait_pulse();
    @(negedge CLK_I);
    r_ext = mask;
    repeat (10) @(negedge CLK_I);
    r_ext = 8'h00;
    wait_pulse();
    wait_pulse();
    repeat (3) @(negedge CLK_I);
  endtask

  logic [7:0] d;
  logic [7:0] m;

  initial begin
    RST_N = 1'b0; WE_I = 1'b0; TGA_I = 1'b0; STB_I = 1'b0;
    ADR_I = 8'h00; DAT_I = 8'h00;

    // Reset state and register map.
    repeat (3) @(negedge CLK_I);
    check("pins in reset", pin_obs(), 16'h0000);
    RST_N = 1'b1;
    for (int a = 0; a < 10; a++) begin
      bus_read(8'(a), 1'b1, d);
      check($sformatf("reg%0d reset", a), {8'h00, d}, 16'h0000);
    end
    bus_write(8'd10, 8'h5A);
    bus_read(8'd10, 1'b1, d);
    check("reg10 reads zero", {8'h00, d}, 16'h0000);
    bus_write(8'd9, 8'h77);
    bus_read(8'd9, 1'b1, d);
    check("cyccount read-only", {8'h00, d}, 16'h0000);

    // Bus pass-through and acknowledge decode.
    @(negedge CLK_I);
    STB_I = 1'b0; DAT_I = 8'hA5;
    #2 check("not addressed dat", {8'h00, DAT_O}, 16'h00A5);
    STB_I = 1'b1; TGA_I = 1'b1; ADR_I = 8'h10;
    #2 check("foreign addr dat", {8'h00, DAT_O}, 16'h00A5);
    check("foreign addr ack", {15'd0, ACK_O}, 16'h0000);
    ADR_I = 8'h02;
    #2 check("own addr ack", {15'd0, ACK_O}, 16'h0001);
    check("stall", {15'd0, STALL_O}, 16'h0000);
    @(negedge CLK_I);
    STB_I = 1'b0; TGA_I = 1'b0; DAT_I = 8'h00; ADR_I = 8'h00;

    // enmask == 0: a charge pulse must not start a cycle.
    wait_pulse();
    @(negedge CLK_I);
    r_ext = 8'hFF;
    repeat (6) @(negedge CLK_I);
    check("mask0 no drive", pin_obs(), 16'h0000);
    repeat (4) @(negedge CLK_I);
    r_ext = 8'h00;
    repeat (30) @(negedge CLK_I);
    check("mask0 idle", pin_obs(), 16'h0000);
    bus_read(8'd9, 1'b1, d);
    check("mask0 cyccount", {8'h00, d}, 16'h0000);

    // Full cycle: channel n discharges after n+1 ticks.
    for (int n = 0; n < 8; n++)
      bus_write(8'(n), 8'(n + 1));
    bus_write(8'd8, 8'hFF);
    wait_pulse();
    @(negedge CLK_I);
    r_ext = 8'hFF;
    repeat (5) @(negedge CLK_I);
    check("full detect", pin_obs(), 16'hFFFF);
    repeat (5) @(negedge CLK_I);
    r_ext = 8'h00;
    wait_pulse();
    for (int k = 0; k < 10; k++) begin
      repeat (5) @(negedge CLK_I);
      m = 8'hFF;
      m = m << k;
      check($sformatf("full tick%0d", k), pin_obs(), (k <= 8) ? {8'hFF, m} : 16'h0000);
      if (k < 9)
        wait_pulse();
    end
    bus_read(8'd9, 1'b1, d);
    check("full cyccount", {8'h00, d}, 16'h0001);

    // Zero discharge time on a single channel; poll reporting.
    bus_write(8'd3, 8'h00);
    bus_write(8'd8, 8'h08);
    wait_pulse();
    @(negedge CLK_I);
    r_ext = 8'h08;
    repeat (5) @(negedge CLK_I);
    check("dt0 detect", pin_obs(), 16'h0808);
    repeat (5) @(negedge CLK_I);
    r_ext = 8'h00;
    repeat (5) @(negedge CLK_I);
    check("dt0 guard", pin_obs(), 16'h0808);
    wait_pulse();
    repeat (5) @(negedge CLK_I);
    check("dt0 release", pin_obs(), 16'h0800);
    wait_pulse();
    repeat (5) @(negedge CLK_I);
    check("dt0 idle", pin_obs(), 16'h0000);
    bus_read(8'd0, 1'b0, d);
    check("poll after cycle", {8'h00, d}, c_poll_done);
    bus_read(8'd9, 1'b1, d);
    check("dt0 cyccount", {8'h00, d}, 16'h0002);
    bus_read(8'd0, 1'b0, d);
    check("poll after read", {8'h00, d}, 16'h0000);

    // Reset in the middle of COUNT.
    for (int n = 0; n < 8; n++)
      bus_write(8'(n), 8'd200);
    bus_write(8'd8, 8'hFF);
    wait_pulse();
    @(negedge CLK_I);
    r_ext = 8'hFF;
    repeat (10) @(negedge CLK_I);
    r_ext = 8'h00;
    wait_pulse();
    repeat (5) @(negedge CLK_I);
    check("count before reset", pin_obs(), 16'hFFFF);
    RST_N = 1'b0;
    #1 check("async reset pins", pin_obs(), 16'h0000);
    r_ext = 8'hFF;
    repeat (2) @(negedge CLK_I);
    RST_N = 1'b1;
    bus_read(8'd0, 1'b1, d);
    check("rst dtime0", {8'h00, d}, 16'h0000);
    bus_read(8'd7, 1'b1, d);
    check("rst dtime7", {8'h00, d}, 16'h0000);
    bus_read(8'd8, 1'b1, d);
    check("rst enmask", {8'h00, d}, 16'h0000);
    bus_read(8'd9, 1'b1, d);
    check("rst cyccount", {8'h00, d}, 16'h0000);
    repeat (30) @(negedge CLK_I);
    check("held high no cycle", pin_obs(), 16'h0000);
    r_ext = 8'h00;
    repeat (30) @(negedge CLK_I);
    check("dropped low no cycle", pin_obs(), 16'h0000);
    bus_read(8'd9, 1'b1, d);
    check("no spurious cycle", {8'h00, d}, 16'h0000);

    // cyccount wrap.
    bus_write(8'd8, 8'h08);
    for (int i = 0; i < 255; i++)
      run_cycle(8'h08);
    bus_read(8'd9, 1'b1, d);
    check("cyccount 255", {8'h00, d}, 16'h00FF);
    run_cycle(8'h08);
    bus_read(8'd9, 1'b1, d);
    check("cyccount wrap", {8'h00, d}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/qtr8_sim.md
Name: qtr8_sim

Overview:
- Emulates eight Pololu QTR-RC reflectance channels: the sensor end of the QTR-RC charge/discharge protocol.
- Lets a second FPGA port, or a bench, exercise QTR-RC reader peripherals with programmable per-channel discharge times.
- Sits on the standard peripheral bus (register and poll access) and uses the global `clocks` pulse array.
- Detects the reader's charge pulse, holds each channel high for its own programmed time, drives it low, then releases the lines.

Parameters:
- NCH, 8, number of emulated channels (fixed at 8; reserved for future width).

Ports:
- CLK_I  input  1  system clock
- RST_N  input  1  asynchronous active-low reset
- WE_I  input  1  bus direction; read=0, write=1
- TGA_I  input  1  1=register access, 0=poll
- STB_I  input  1  this peripheral addressed
- ADR_I  input  8  register address
- STALL_O  output  1  always 0
- ACK_O  output  1  =myaddr
- DAT_I  input  8  data in
- DAT_O  output  8  data out; equals DAT_I when not addressed
- clocks  input  `MXCLK+1  global pulse array; uses clocks[`U10CLK]
- pins  inout  8  QTR-RC lines (external weak pull-down on the fixture)

Behaviour:
- Clock and reset: one clock, CLK_I. RST_N is asynchronous and active-low.
- Address decode: myaddr = STB_I && ADR_I[7:4]==0.
- Registers:
  - 0-7: dtime[n], discharge time for channel n in 10us ticks. R/W, reset 8'h00.
  - 8: enmask. R/W, reset 8'h00.
  - 9: cyccount, completed emulation cycles. Read-only, 8-bit, wraps 255->0.
  - 10-15: read 8'h00, writes ignored.
- Reset values: state=IDLE, armed=0, all pins high-Z, cyccount=0, data_avail=0, all per-channel counters 0, DAT_O follows bus mux.
- Input sync: pins pass through a 2-flop synchronizer; psync is the synchronized value.
- States:
  - IDLE: pins Z.
    - armed<=1 when (psync & enmask)==0.
    - If armed and (psync & enmask)!=0 -> DETECT; armed<=0.
    - enmask==0 never triggers.
  - DETECT: enabled pins driven 1 immediately (no contention with the reader's high drive). On 2nd u10clk pulse after entry -> COUNT with tick=0. This guard covers the reader's 10us charge.
  - COUNT: on each u10clk, tick<=tick+1 (9 bits, saturating).
    - Enabled channel n drives 1 while tick < dtime[n], else drives 0.
    - dtime[n]==0 means the channel drives 0 from COUNT entry.
    - When tick >= every enabled dtime -> RELEASE.
  - RELEASE: enabled pins drive 0 for one full u10clk period, then -> IDLE (pins Z); cyccount<=cyccount+1.
- Disabled channels are Z in all states.
- Writes to dtime or enmask mid-cycle take effect on the next comparison. If enmask is cleared to 0 in DETECT/COUNT -> RELEASE on the next cycle.
- Simultaneous events: a bus write and a state update in the same cycle both apply; a write never blocks state progress.
- Reset mid-cycle: pins go Z asynchronously; next trigger requires re-arming.
- Latency: pin high to drive-high is 3 CLK_I cycles (2 sync + 1 register).
- DAT_O mux priority:
  - ~myaddr -> DAT_I
  - ~TGA_I && data_avail -> 8'h01
  - TGA_I -> selected register
  - else 8'h00

Optional Feature:
- QTR8SIM_AUTOSEND_EN
- Defined:
  - data_avail<=1 on each RELEASE->IDLE transition.
  - A poll (~TGA_I) returns 8'h01 while data_avail=1.
  - Any host register read (TGA_I & myaddr & ~WE_I) clears data_avail. A set and a clear in the same cycle: set wins.
- Undefined: data_avail is tied 0 and polls return 8'h00.

Test Plan:
- Reset, then read regs 0-9 -> all 8'h00; pins Z; enmask=0 and pulsing pins high -> no drive, cyccount stays 0.
- enmask=8'hFF, dtime[n]=n+1, external 10us high pulse on all pins -> channel n high for (n+1) u10clk ticks after the guard, then low; RELEASE lasts one tick; cyccount=1; pins Z.
- dtime[3]=0, enmask=8'h08, trigger -> pin 3 high only during DETECT, low from COUNT entry; other pins Z throughout.
- Pins held high externally after a cycle -> no retrigger until pins read low; second trigger then gives cyccount=2. Wrap: 256 cycles -> cyccount=0.
- Assert RST_N mid-COUNT -> pins Z in the same cycle; registers back to 8'h00; pins left high then low -> no spurious cycle.
- With QTR8SIM_AUTOSEND_EN: cycle done -> poll returns 8'h01; read reg 9 -> data_avail cleared, next poll 8'h00. Without the macro: poll always 8'h00.
